// File: rtl/obstacle_streamer_if.sv
// obstacle_streamer_if: bundles the two streaming channels of the obstacle streamer.
//   Row channel      : row_in[11:0], row_in_valid (to streamer), row_in_ready (from streamer)
//   Obstacle channel : obstacle[15:0], obstacle_valid, firstrow (from streamer)
// master = row generator / obstacle consumer side, slave = the streamer itself.
interface obstacle_streamer_if;
  logic [11:0] row_in;
  logic        row_in_valid;
  logic        row_in_ready;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;

  modport master (
    output row_in, row_in_valid,
    input  row_in_ready, obstacle, obstacle_valid, firstrow
  );

  modport slave (
    input  row_in, row_in_valid,
    output row_in_ready, obstacle, obstacle_valid, firstrow
  );
endinterface

// File: rtl/obstacle_streamer.sv
// obstacle_streamer: ring buffer of upcoming track rows. Scrolls by SPEED score
// points per frame and, once per frame, streams every lane of every buffered row
// as a 16-bit obstacle word {type[2:0], lane[1:0], depth[10:0]}.
//
// Ports
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_new_frame      : 1-cycle frame strobe
//   i_halt           : freeze scrolling; streaming continues
//   bus (slave)      : row input handshake and obstacle word output
//   o_frame_done     : 1-cycle pulse after the last word of a frame
//   o_phase          : scroll offset within row 0
//   o_underflow      : sticky, row 0 retired with no replacement offered
//   o_overrun        : sticky, new_frame seen outside IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting rows, waiting for new_frame
// ADVANCE  | one cycle: scroll phase, possibly retire row 0
// STREAM   | one word per cycle, 3*ROWS words, lane-major within row
// DONE     | one cycle: frame_done pulse, then back to IDLE
module obstacle_streamer #(
  parameter int HALF_BLOCK_LENGTH = 64,
  parameter int SPEED             = 4,
  parameter int ROWS              = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_new_frame,
  input  logic                                 i_halt,
  obstacle_streamer_if.slave                   bus,
  output logic                                 o_frame_done,
  output logic [$clog2(HALF_BLOCK_LENGTH)-1:0] o_phase,
  output logic                                 o_underflow,
  output logic                                 o_overrun
);

  localparam int PW = $clog2(HALF_BLOCK_LENGTH);
  localparam int HW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADVANCE, S_STREAM, S_DONE} state_t;

  state_t        r_state;
  logic [HW-1:0] r_head;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_phase;
  logic [HW-1:0] r_row;
  logic [1:0]    r_lane;
  logic [11:0]   r_mem [ROWS];
  logic [15:0]   r_obstacle;
  logic          r_valid;
  logic          r_firstrow;
  logic          r_frame_done;
  logic          r_underflow;
  logic          r_overrun;

  logic          w_xfer;
  logic          w_adv_wrap;
  logic [PW-1:0] w_adv_phase;
  logic [HW-1:0] w_adv_head;
  logic [CW-1:0] w_adv_count;
  logic [HW-1:0] w_sel_row;
  logic [1:0]    w_sel_lane;
  logic [HW-1:0] w_sel_head;
  logic [CW-1:0] w_sel_count;
  logic [PW-1:0] w_sel_phase;
  logic [HW-1:0] w_rd_idx;
  logic [HW-1:0] w_wr_idx;
  logic [11:0]   w_row_data;
  logic [3:0]    w_nib;
  logic [2:0]    w_type;
  logic          w_ramp2;
  int            w_depth;
  logic [15:0]   w_word;
  logic          w_last;

  function automatic logic [HW-1:0] wrap_add(input int a, input int b);
    int s;
    s = a + b;
    if (s >= ROWS) s = s - ROWS;
    return HW'(s);
  endfunction

  assign bus.row_in_ready = (r_state == S_IDLE) && (r_count < CW'(ROWS));
  assign w_xfer           = bus.row_in_valid && bus.row_in_ready;

  assign w_adv_wrap  = (int'(r_phase) + SPEED) >= HALF_BLOCK_LENGTH;
  assign w_adv_phase = w_adv_wrap ? '0 : PW'(int'(r_phase) + SPEED);
  assign w_adv_head  = w_adv_wrap ? wrap_add(int'(r_head), 1) : r_head;
  assign w_adv_count = w_adv_wrap ? r_count - CW'(1) : r_count;

  assign w_last = (r_row == HW'(ROWS - 1)) && (r_lane == 2'd2);

  // Selects the word to be registered at the coming edge. Entering STREAM from
  // ADVANCE must already see the scrolled phase/head/count, so those are taken
  // from the advance results rather than the registers.
  always_comb begin
    w_sel_row   = '0;
    w_sel_lane  = '0;
    w_sel_head  = r_head;
    w_sel_count = r_count;
    w_sel_phase = r_phase;
    case (r_state)
      S_ADVANCE: begin
        w_sel_head  = w_adv_head;
        w_sel_count = w_adv_count;
        w_sel_phase = w_adv_phase;
      end
      S_STREAM: begin
        if (r_lane == 2'd2) begin
          w_sel_lane = 2'd0;
          w_sel_row  = r_row + HW'(1);
        end else begin
          w_sel_lane = r_lane + 2'd1;
          w_sel_row  = r_row;
        end
      end
      default: ;
    endcase
  end

  assign w_rd_idx = wrap_add(int'(w_sel_head), int'(w_sel_row));
  assign w_wr_idx = wrap_add(int'(r_head), int'(r_count));

  // Slots past count read as empty. A row arriving in the same IDLE cycle as
  // new_frame is forwarded so word 0 agrees with the rest of the stream.
  always_comb begin
    w_row_data = '0;
    if (int'(w_sel_row) < int'(w_sel_count))
      w_row_data = r_mem[w_rd_idx];
    else if ((r_state == S_IDLE) && w_xfer && (int'(w_sel_row) == int'(r_count)))
      w_row_data = bus.row_in;
  end

  always_comb begin
    case (w_sel_lane)
      2'd0:    w_nib = w_row_data[3:0];
      2'd1:    w_nib = w_row_data[7:4];
      default: w_nib = w_row_data[11:8];
    endcase
  end

  assign w_type  = w_nib[2:0];
  assign w_ramp2 = w_nib[3];

  always_comb begin
    w_depth = 0;
    if (w_type == 3'b101)
      w_depth = (w_ramp2 ? 0 : HALF_BLOCK_LENGTH) + int'(w_sel_phase);
    else
      w_depth = int'(w_sel_row) * HALF_BLOCK_LENGTH + (HALF_BLOCK_LENGTH - 1 - int'(w_sel_phase));
  end

  assign w_word = {w_type, w_sel_lane, w_depth[10:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_xfer) r_mem[w_wr_idx] <= bus.row_in;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_count      <= '0;
      r_phase      <= '0;
      r_row        <= '0;
      r_lane       <= '0;
      r_obstacle   <= '0;
      r_valid      <= 1'b0;
      r_firstrow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_obstacle   <= '0;
      r_valid      <= 1'b0;
      r_firstrow   <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_xfer) r_count <= r_count + CW'(1);
      if (i_new_frame && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_new_frame) begin
            if (!i_halt && (r_count == CW'(ROWS))) begin
              r_state <= S_ADVANCE;
            end else begin
              r_state    <= S_STREAM;
              r_row      <= '0;
              r_lane     <= '0;
              r_obstacle <= w_word;
              r_valid    <= 1'b1;
              r_firstrow <= 1'b1;
            end
          end
        end
        S_ADVANCE: begin
          r_phase <= w_adv_phase;
          r_head  <= w_adv_head;
          r_count <= w_adv_count;
          if (w_adv_wrap && !bus.row_in_valid) r_underflow <= 1'b1;
          r_state    <= S_STREAM;
          r_row      <= '0;
          r_lane     <= '0;
          r_obstacle <= w_word;
          r_valid    <= 1'b1;
          r_firstrow <= 1'b1;
        end
        S_STREAM: begin
          if (w_last) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end else begin
            r_row      <= w_sel_row;
            r_lane     <= w_sel_lane;
            r_obstacle <= w_word;
            r_valid    <= 1'b1;
            r_firstrow <= (w_sel_row == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.obstacle       = r_obstacle;
  assign bus.obstacle_valid = r_valid;
  assign bus.firstrow       = r_firstrow;
  assign o_frame_done       = r_frame_done;
  assign o_phase            = r_phase;
  assign o_underflow        = r_underflow;
  assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_obstacle_streamer.sv
// Testbench for obstacle_streamer: table-driven push/frame vectors, directed
// corner sequences and randomized frames against a queue-based reference model.
module tb_obstacle_streamer;
  localparam int HBL   = 64;
  localparam int SPEED = 4;
  localparam int ROWS  = 8;
  localparam int NW    = 3 * ROWS;

  logic       clk;
  logic       rst_n;
  logic       new_frame;
  logic       halt;
  logic       frame_done;
  logic [5:0] phase;
  logic       underflow;
  logic       overrun;

  obstacle_streamer_if bus();

  obstacle_streamer #(.HALF_BLOCK_LENGTH(HBL), .SPEED(SPEED), .ROWS(ROWS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_new_frame (new_frame),
    .i_halt      (halt),
    .bus         (bus),
    .o_frame_done(frame_done),
    .o_phase     (phase),
    .o_underflow (underflow),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model: queue front is row 0
  logic [11:0] mq[$];
  int          mphase;
  logic        munder;
  logic        mover;

  logic [15:0] got_w  [NW];
  logic        got_fr [NW];
  int          got_n;
  int          got_first;

  typedef struct {
    logic [11:0] row;
    logic        valid;
    logic        exp_ready;
  } push_vec_t;

  typedef struct {
    logic halt;
    int   exp_phase;
    int   exp_lat;
    int   exp_d0;
    int   exp_d3;
  } frame_vec_t;

  push_vec_t  pv [9];
  frame_vec_t fv [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] exp_word(input int r, input int l);
    logic [11:0] row;
    logic [3:0]  nib;
    int          d;
    row = (r < mq.size()) ? mq[r] : 12'h000;
    nib = row[4*l +: 4];
    if (nib[2:0] == 3'b101) d = (nib[3] ? 0 : HBL) + mphase;
    else                    d = r * HBL + HBL - 1 - mphase;
    return {(r == 0), nib[2:0], l[1:0], d[10:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; new_frame = 1'b0; halt = 1'b0;
    bus.row_in_valid = 1'b0; bus.row_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); mphase = 0; munder = 1'b0; mover = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"},      bus.obstacle_valid, 0);
    chk({tag, "_obstacle"},   bus.obstacle, 0);
    chk({tag, "_firstrow"},   bus.firstrow, 0);
    chk({tag, "_ready"},      bus.row_in_ready, 1);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_phase"},      phase, 0);
    chk({tag, "_underflow"},  underflow, 0);
    chk({tag, "_overrun"},    overrun, 0);
  endtask

  task automatic push(input logic [11:0] d, input logic v);
    bus.row_in = d; bus.row_in_valid = v;
    chk("push_ready", bus.row_in_ready, mq.size() < ROWS);
    chk("idle_no_word", bus.obstacle_valid, 0);
    if (v && mq.size() < ROWS) mq.push_back(d);
    @(negedge clk);
    bus.row_in_valid = 1'b0;
  endtask

  // One frame: h = halt, v = row_in_valid held while the frame runs,
  // inj = cycle (1..NW) at which an extra new_frame is pulsed, 0 for none.
  task automatic run_frame(input logic h, input logic v, input int inj);
    logic [16:0] expw [NW];
    int exp_lat, cyc, first, last, done_at;
    bit scroll;
    scroll = !h && (mq.size() == ROWS);
    if (scroll) begin
      mphase += SPEED;
      if (mphase >= HBL) begin
        mphase = 0;
        void'(mq.pop_front());
        if (!v) munder = 1'b1;
      end
    end
    exp_lat = scroll ? 2 : 1;
    for (int i = 0; i < NW; i++) expw[i] = exp_word(i / 3, i % 3);
    if (inj > 0) mover = 1'b1;
    for (int i = 0; i < NW; i++) begin got_w[i] = '0; got_fr[i] = 1'b0; end

    halt = h; new_frame = 1'b1; bus.row_in_valid = 1'b0;
    @(negedge clk);
    new_frame = 1'b0; bus.row_in_valid = v; bus.row_in = 12'($urandom);
    cyc = 1; got_n = 0; first = -1; last = -1; done_at = -1;
    while (done_at < 0 && cyc <= NW + 6) begin
      if (bus.obstacle_valid) begin
        if (first < 0) first = cyc;
        if (got_n < NW) begin
          got_w[got_n]  = bus.obstacle;
          got_fr[got_n] = bus.firstrow;
        end
        got_n++;
        last = cyc;
      end
      if (frame_done) done_at = cyc;
      else begin
        if (cyc == inj) new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        cyc++;
      end
    end
    chk("frame_done_seen",    done_at >= 0, 1);
    chk("word_count",         got_n, NW);
    chk("first_word_latency", first, exp_lat);
    chk("no_gaps",            last - first + 1, got_n);
    chk("frame_done_timing",  done_at, last + 1);
    for (int i = 0; i < NW; i++)
      chk($sformatf("word[%0d]", i), {got_fr[i], got_w[i]}, expw[i]);
    chk("phase",     phase, mphase);
    chk("underflow", underflow, munder);
    chk("overrun",   overrun, mover);
    got_first = first;
    bus.row_in_valid = 1'b0; halt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    pv[0] = '{12'h321, 1'b1, 1'b1};
    pv[1] = '{12'h642, 1'b1, 1'b1};
    pv[2] = '{12'h0D5, 1'b1, 1'b1};
    pv[3] = '{12'h714, 1'b1, 1'b1};
    pv[4] = '{12'h000, 1'b1, 1'b1};
    pv[5] = '{12'hA63, 1'b1, 1'b1};
    pv[6] = '{12'h257, 1'b1, 1'b1};
    pv[7] = '{12'h416, 1'b1, 1'b1};
    pv[8] = '{12'h777, 1'b1, 1'b0};
    fv[0] = '{1'b0, 4, 2, 59, 123};
    fv[1] = '{1'b1, 4, 1, 59, 123};
    fv[2] = '{1'b0, 8, 2, 55, 119};

    do_reset();
    check_reset_state("reset");

    // fill the buffer; ready drops once eight rows are held
    for (int i = 0; i < 9; i++) begin
      bus.row_in = pv[i].row; bus.row_in_valid = pv[i].valid;
      chk($sformatf("tbl_ready[%0d]", i), bus.row_in_ready, pv[i].exp_ready);
      chk("no_word_before_frame", bus.obstacle_valid, 0);
      if (pv[i].valid && mq.size() < ROWS) mq.push_back(pv[i].row);
      @(negedge clk);
    end
    bus.row_in_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_frame(fv[i].halt, 1'b0, 0);
      chk($sformatf("tbl_phase[%0d]", i),   phase, fv[i].exp_phase);
      chk($sformatf("tbl_latency[%0d]", i), got_first, fv[i].exp_lat);
      chk($sformatf("tbl_depth0[%0d]", i),  got_w[0][10:0], fv[i].exp_d0);
      chk($sformatf("tbl_depth3[%0d]", i),  got_w[3][10:0], fv[i].exp_d3);
      chk($sformatf("tbl_fr012[%0d]", i),   {got_fr[0], got_fr[1], got_fr[2], got_fr[3]}, 4'b1110);
    end

    // scroll to the row wrap with a replacement row offered
    for (int i = 0; i < 20; i++) begin
      run_frame(1'b0, 1'b1, 0);
      if (mphase == 0) break;
    end
    chk("wrap_phase", phase, 0);
    chk("wrap_ready", bus.row_in_ready, 1);
    push(12'h135, 1'b1);
    chk("refill_ready", bus.row_in_ready, 0);
    chk("wrap_no_underflow", underflow, 0);

    // scroll to the wrap with no replacement row
    for (int i = 0; i < 20; i++) begin
      run_frame(1'b0, 1'b0, 0);
      if (mphase == 0) break;
    end
    chk("underflow_set", underflow, 1);
    run_frame(1'b0, 1'b0, 0);
    chk("short_buffer_no_scroll", got_first, 1);
    chk("short_buffer_phase", phase, 0);
    for (int i = 21; i < 24; i++)
      chk($sformatf("row7_empty[%0d]", i), got_w[i][15:13], 0);

    // ramp lanes in row 0
    do_reset();
    push(12'h5D0, 1'b1);
    for (int i = 0; i < 7; i++) push(12'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b1, 0);
    chk("ramp_phase", phase, 20);
    chk("ramp_l1_word", got_w[1], {3'b101, 2'd1, 11'd20});
    chk("ramp_l2_word", got_w[2], {3'b101, 2'd2, 11'd84});

    // halted frames, one with a stray new_frame mid-stream
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b1, 1'b0, (i == 1) ? 5 : 0);
      chk("halt_phase", phase, 20);
      chk("halt_words", got_n, NW);
    end
    chk("overrun_set", overrun, 1);

    // reset in the middle of a stream
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    repeat (6) @(negedge clk);
    chk("midstream_active", bus.obstacle_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midrst");
    mq.delete(); mphase = 0; munder = 1'b0; mover = 1'b0;
    run_frame(1'b0, 1'b0, 0);
    chk("midrst_empty_row0", got_w[0][15:13], 0);

    // randomized traffic
    do_reset();
    for (int f = 0; f < 40; f++) begin
      np = $urandom_range(0, 10);
      for (int p = 0; p < np; p++) push(12'($urandom), $urandom_range(0, 3) != 0);
      run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NW)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/obstacle_streamer.md
Name: obstacle_streamer

Overview:
- Source end of the obstacle word stream consumed by the player/collision logic.
- Holds a ring buffer of upcoming track rows fed by the row generator.
- Scrolls the buffer by SPEED score points each frame.
- Once per frame, serialises every lane of every buffered row as a 16-bit obstacle word, with valid and firstrow strobes, for collision checking and rendering.

Parameters:
- HALF_BLOCK_LENGTH, 64: score points per row; must be a power of two.
- SPEED, 4: score points scrolled per frame; must divide HALF_BLOCK_LENGTH.
- ROWS, 8: ring buffer depth in rows, 2..16; row 0 is the row the player occupies.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: synchronous, active-low reset.
- new_frame  in  1: 1-cycle frame strobe.
- halt  in  1: freeze scrolling (game over); streaming continues.
- row_in  in  12: per lane l, bits [4l+3:4l] = {ramp_second_half, type[2:0]}.
- row_in_valid  in  1: row_in holds a row.
- row_in_ready  out  1: buffer accepts a row this cycle.
- obstacle  out  16: [15:13] type, [12:11] lane, [10:0] depth.
- obstacle_valid  out  1: obstacle word valid this cycle.
- firstrow  out  1: word belongs to row 0.
- frame_done  out  1: 1-cycle pulse after the last word of a frame.
- phase  out  $clog2(HALF_BLOCK_LENGTH): scroll offset within row 0.
- underflow  out  1: sticky; a row was retired with no replacement available.
- overrun  out  1: sticky; new_frame arrived while not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, regardless of state, including mid-stream:
  - buffer empty (count=0), head=0, phase=0, state IDLE;
  - all outputs 0, except row_in_ready=1.
- Handshake: a row transfers on any edge with row_in_valid && row_in_ready.
  - The row is written at (head+count) mod ROWS and count increments.
  - row_in_ready = (state==IDLE) && (count<ROWS).
- Buffer slots at index ≥ count read as all lanes type 000, ramp bit 0.
- FSM states: IDLE, ADVANCE, STREAM, DONE.
- IDLE, on new_frame:
  - If !halt and count==ROWS, go to ADVANCE.
  - Otherwise go to STREAM with row=0, lane=0; no scroll occurs (the pipeline waits for a full buffer before moving).
- ADVANCE (1 cycle), update phase:
  - If phase+SPEED < HALF_BLOCK_LENGTH: phase += SPEED.
  - Else: phase=0, head=(head+1) mod ROWS, count -= 1 (row 0 retires). If row_in_valid was low in that cycle, set underflow.
  - Then go to STREAM with row=0, lane=0.
- STREAM emits one word per cycle, lane-major within row: (r0,l0), (r0,l1), (r0,l2), (r1,l0), … — exactly 3*ROWS words, with no gaps.
  - Words for empty type 000 are also emitted; the consumer uses them to set ground level.
  - obstacle_valid=1 on every STREAM cycle; firstrow=1 iff r==0.
  - Word fields: type and lane = l.
  - Depth, non-ramp (type≠101): r*HALF_BLOCK_LENGTH + (HALF_BLOCK_LENGTH-1-phase), truncated to 11 bits.
  - Depth, ramp (type 101): (ramp_second_half ? 0 : HALF_BLOCK_LENGTH) + phase. This yields 0..HBL-1 for the second half and HBL..2HBL-1 for the first half.
- Outputs are registered; the first word appears 2 cycles after new_frame with scroll, 1 cycle without.
- DONE (1 cycle): frame_done=1, obstacle_valid=0, then return to IDLE.
- new_frame in ADVANCE, STREAM or DONE is dropped and sets overrun; the stream in progress is unaffected.
- halt held: phase and head are frozen, but every new_frame still produces a full stream.
- Sticky flags clear only on reset.
- Lane encoding 3 is never emitted.

Test Plan:
- Reset then 8 rows pushed back-to-back:
  - row_in_ready falls after the 8th transfer;
  - count=8, no words emitted before the first new_frame.
- Full buffer, phase=0, new_frame:
  - ADVANCE gives phase=4;
  - 24 consecutive valid words;
  - first word depth 59 with firstrow=1, words 0-2 have firstrow=1;
  - word 3 (r1,l0) depth 123;
  - frame_done 1 cycle after word 23.
- Scroll through 16 frames with row_in_valid high:
  - 16th frame wraps phase to 0, head advances, row_in_ready rises;
  - the next row is accepted in IDLE before the following new_frame;
  - underflow stays 0.
- Same scroll with row_in_valid low:
  - underflow=1;
  - the next frame streams without scrolling (count=7);
  - row 7 words all have type 000.
- Ramp row in row 0 lanes 1 (second half) and 2 (first half), phase=20:
  - lane-1 depth 20; lane-2 depth 84.
- halt=1, 3 new_frames:
  - phase is unchanged across all 3;
  - each new_frame yields 24 words;
  - new_frame pulsed during STREAM sets overrun, stream length stays 24.
- rst_n=0 asserted mid-STREAM:
  - next cycle obstacle_valid=0, state IDLE, count=0, flags cleared.
